// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit. Latches operand
//               magnitudes and sign flags on an accepted start, runs a
//               width-cycle shift-add multiply or restoring divide, then
//               applies the sign fix on entry to DONE. Divide-by-zero and
//               signed overflow finish in a single edge.
// Ports       : clock  - rising-edge clock
//               clear  - asynchronous active-low reset
//               start  - request, sampled only while idle
//               funct3 - RV32M operation (MUL..REMU)
//               opA    - rs1 value
//               opB    - rs2 value
//               busy   - high whenever not idle
//               done   - one-cycle pulse carrying a valid result
//               result - writeback value, held until the next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int width = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] opA,
    input  logic [width-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam int c_CNT_W = $clog2(width + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    // r_hi: product high half (mul) or partial remainder (div).
    // r_lo: multiplier shifting out / product low half (mul), or
    //       dividend shifting out / quotient shifting in (div).
    // r_opnd: multiplicand (mul) or divisor (div).
    logic [width:0]     r_hi;
    logic [width-1:0]   r_lo;
    logic [width-1:0]   r_opnd;
    logic [width-1:0]   r_result;

    // ---------------------------------------------------------------- decode
    logic             w_is_div;
    logic             w_signed_div;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [width-1:0] w_special_res;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [width-1:0] w_mag_a;
    logic [width-1:0] w_mag_b;

    assign w_is_div     = funct3[2];
    assign w_signed_div = funct3[2] & ~funct3[0];
    assign w_div_zero   = (opB == '0);
    assign w_ovf        = w_signed_div
                          && (opA == {1'b1, {(width-1){1'b0}}})
                          && (opB == '1);
    assign w_special    = w_is_div & (w_div_zero | w_ovf);

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? opA : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : opA;
        end
    end

    // opA is signed for MULH, MULHSU, DIV, REM; opB for MULH, DIV, REM.
    assign w_sign_a = opA[width-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                      (funct3 == 3'b100) | (funct3 == 3'b110));
    assign w_sign_b = opB[width-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                      (funct3 == 3'b110));
    assign w_mag_a  = w_sign_a ? (~opA + 1'b1) : opA;
    assign w_mag_b  = w_sign_b ? (~opB + 1'b1) : opB;

    // ------------------------------------------------------------ iteration
    logic [width:0] w_mul_sum;
    logic [width:0] w_rem_sh;
    logic           w_rem_ge;
    logic [width:0] w_rem_sub;

    // Right-shifting accumulator: adding the multiplicand into the high half
    // and shifting right is the same as adding it shifted left by the bit index.
    assign w_mul_sum = {1'b0, r_hi[width-1:0]} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // The partial remainder is always below the divisor, so width+1 bits
    // hold it after shifting in the next dividend bit.
    assign w_rem_sh  = {r_hi[width-1:0], r_lo[width-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub = w_rem_sh - {1'b0, r_opnd};

    // ------------------------------------------------------------- sign fix
    logic [2*width-1:0] w_prod;
    logic [2*width-1:0] w_prod_fix;
    logic [width-1:0]   w_quo_fix;
    logic [width-1:0]   w_rem_fix;
    logic [width-1:0]   w_final;

    assign w_prod     = {r_hi[width-1:0], r_lo};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem_fix  = r_sign_a ? (~r_hi[width-1:0] + 1'b1) : r_hi[width-1:0];

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_fix[width-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*width-1:width];
            3'b100, 3'b101:         w_final = w_quo_fix;
            default:                w_final = w_rem_fix;
        endcase
    end

    // ----------------------------------------------------------- sequential
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= c_DONE;
                        end else begin
                            r_op     <= funct3;
                            r_sign_a <= w_sign_a;
                            r_sign_b <= w_sign_b;
                            r_hi     <= '0;
                            r_lo     <= w_is_div ? w_mag_a : w_mag_b;
                            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                            r_cnt    <= '0;
                            r_state  <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    if (r_cnt == c_CNT_W'(width)) begin
                        // All iterations complete: this edge only fixes signs.
                        r_result <= w_final;
                        r_state  <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op[2]) begin
                            r_hi <= w_rem_ge ? w_rem_sub : w_rem_sh;
                            r_lo <= {r_lo[width-2:0], w_rem_ge};
                        end else begin
                            r_hi <= {1'b0, w_mul_sum[width:1]};
                            r_lo <= {w_mul_sum[0], r_lo[width-1:1]};
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit. Expected
//               results and latencies are hand-computed constants.
//               Latency is the index of the edge after which done is seen,
//               counting the accepting edge as edge 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.width(32)) u_dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .funct3 (funct3),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, wait for
    // done within a bound, then check latency, result and return to idle.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clock);
        funct3 = f; opA = a; opB = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; funct3 = ~f; opA = ~a; opB = ~b;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result, exp);
        @(posedge clock); #1;
        chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, " held"}, result, exp);
    endtask

    initial begin
        int seen_done;
        int lat;
        clear = 1'b0; start = 1'b0; funct3 = 3'd0; opA = '0; opB = '0;
        #12;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clock);
        clear = 1'b1;

        run_op("MUL 7*-3",       3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULHU 7*-3",     3'b011, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, 33);
        run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("MULHSU -1*-1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("MULHU -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,        33);
        run_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        32'd2,         33);
        run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
        run_op("DIV 5/0",        3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
        run_op("REM 5/0",        3'b110, 32'd5,        32'd0,        32'd5,         0);
        run_op("REMU 5/0",       3'b111, 32'd5,        32'd0,        32'd5,         0);

        // Busy handling: starts at edges 5 and 33 of a MUL must be ignored.
        @(negedge clock);
        funct3 = 3'b000; opA = 32'd7; opB = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy after accept", {31'd0, busy}, 32'd1);
        repeat (4) begin @(posedge clock); #1; end
        @(negedge clock);
        funct3 = 3'b011; opA = 32'd3; opB = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("edge5 still busy", {30'd0, busy, done}, 32'd2);
        repeat (27) begin @(posedge clock); #1; end
        @(negedge clock);
        funct3 = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        chk("edge33 done", {30'd0, busy, done}, 32'd3);
        chk("edge33 result", result, 32'hFFFF_FFEB);
        // start still high while DONE is sampled: ignored, unit returns idle.
        @(posedge clock); #1;
        chk("edge34 idle", {30'd0, busy, done}, 32'd0);
        chk("edge34 result", result, 32'hFFFF_FFEB);
        // First edge that samples busy=0 accepts the pending request.
        @(posedge clock); #1;
        start = 1'b0;
        chk("next accepted", {31'd0, busy}, 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("next latency", lat, 33);
        chk("next result", result, 32'd14);

        // Reset in the middle of a DIV.
        @(posedge clock); #1;
        @(negedge clock);
        funct3 = 3'b100; opA = 32'hFFFF_FFF9; opB = 32'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        clear = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen_done++;
        end
        @(negedge clock);
        clear = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen_done++;
        end
        chk("no done after abort", seen_done, 0);
        run_op("DIV after reset", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
